// File: rtl/max_seq_ctrl.sv
// Frame sequencer for the unsigned max-compare datapath: accepts frame_len words, reports max.
// Define MAX_SEQ_ARGMAX_EN to add the idx register and the out_idx port.
module max_seq_ctrl #(
  parameter int W  = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_max,
  output logic          busy
`ifdef MAX_SEQ_ARGMAX_EN
  ,
  output logic [LW-1:0] out_idx
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_max   <= '0;
`ifdef MAX_SEQ_ARGMAX_EN
      out_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start && frame_len != '0) begin
            len      <= frame_len;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready) begin
            // First word seeds the running max; strict compare keeps the earliest tie.
            if (count == '0 || in_data > out_max) begin
              out_max <= in_data;
`ifdef MAX_SEQ_ARGMAX_EN
              out_idx <= count;
`endif
            end
            if (count == len - 1'b1) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_seq_ctrl.sv
// Directed bench for max_seq_ctrl; out_idx checks are compiled in with MAX_SEQ_ARGMAX_EN.
module tb_max_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] frame_len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_max;
  logic       busy;
`ifdef MAX_SEQ_ARGMAX_EN
  logic [7:0] out_idx;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;

  max_seq_ctrl #(.W(8), .LW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .busy(busy)
`ifdef MAX_SEQ_ARGMAX_EN
    , .out_idx(out_idx)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_idx(input string tag, input logic [7:0] exp);
`ifdef MAX_SEQ_ARGMAX_EN
    check(tag, {24'd0, out_idx}, {24'd0, exp});
`else
    if (exp === 8'hxx) $display("unused %s", tag);
`endif
  endtask

  // Pulses start, then scrambles frame_len to prove the latched copy is used.
  task automatic start_frame(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    frame_len = n;
    @(negedge clk);
    start = 1'b0;
    frame_len = ~n;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy_drop"},  {31'd0, busy},      32'd0);
  endtask

  logic [7:0] rnd [255];
  logic [7:0] ref_max;
  logic [7:0] ref_idx;

  initial begin
    // reset state
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_max", {24'd0, out_max}, 32'd0);
    check_idx("rst_out_idx", 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // T1: reset mid-frame after 2 of 4 words
    start_frame(8'd4);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    push(8'h33);
    push(8'h44);
    rst = 1'b1;
    #1;
    check("t1_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("t1_rst_busy", {31'd0, busy}, 32'd0);
    check("t1_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t1_rst_out_max", {24'd0, out_max}, 32'd0);
    check_idx("t1_rst_out_idx", 8'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hEE;
    @(negedge clk);
    in_valid = 1'b0;
    check("t1_idle_in_ready", {31'd0, in_ready}, 32'd0);
    check("t1_idle_out_max", {24'd0, out_max}, 32'd0);

    // T2: basic frame
    start_frame(8'd4);
    push(8'd3);
    push(8'd9);
    check("t2_no_early_valid", {31'd0, out_valid}, 32'd0);
    push(8'd2);
    check("t2_in_ready_mid", {31'd0, in_ready}, 32'd1);
    push(8'd7);
    check("t2_out_valid", {31'd0, out_valid}, 32'd1);
    check("t2_in_ready_done", {31'd0, in_ready}, 32'd0);
    check("t2_out_max", {24'd0, out_max}, 32'd9);
    check_idx("t2_out_idx", 8'd1);
    take("t2");

    // T3: ties keep the earlier word
    start_frame(8'd3);
    push(8'd5);
    push(8'd5);
    push(8'd4);
    check("t3_out_valid", {31'd0, out_valid}, 32'd1);
    check("t3_out_max", {24'd0, out_max}, 32'd5);
    check_idx("t3_out_idx", 8'd0);
    take("t3");

    // T4: result backpressure; start and in_valid ignored in DONE
    start_frame(8'd2);
    push(8'h80);
    push(8'hFF);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_max", {24'd0, out_max}, 32'hFF);
      check("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
      start = 1'b1;
      frame_len = 8'd3;
      in_valid = 1'b1;
      in_data = 8'h01;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    check_idx("t4_out_idx", 8'd1);
    take("t4");
    @(negedge clk);
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    check("t4_idle_max", {24'd0, out_max}, 32'hFF);

    // T5: zero-length start ignored, single-word frame, full-length random frame
    start_frame(8'd0);
    check("t5_zero_busy", {31'd0, busy}, 32'd0);
    check("t5_zero_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("t5_zero_valid", {31'd0, out_valid}, 32'd0);
    start_frame(8'd1);
    push(8'd0);
    check("t5_one_valid", {31'd0, out_valid}, 32'd1);
    check("t5_one_max", {24'd0, out_max}, 32'd0);
    check_idx("t5_one_idx", 8'd0);
    take("t5_one");
    ref_max = '0;
    ref_idx = '0;
    for (int i = 0; i < 255; i++) begin
      rnd[i] = 8'($urandom_range(0, 250));
      if (i == 0 || rnd[i] > ref_max) begin
        ref_max = rnd[i];
        ref_idx = 8'(i);
      end
    end
    start_frame(8'd255);
    for (int i = 0; i < 255; i++) push(rnd[i]);
    check("t5_full_valid", {31'd0, out_valid}, 32'd1);
    check("t5_full_max", {24'd0, out_max}, {24'd0, ref_max});
    check_idx("t5_full_idx", ref_idx);
    take("t5_full");

    // T6: bubbles between valid beats
    start_frame(8'd3);
    push(8'd1);
    in_data = 8'hAA;
    @(negedge clk);
    push(8'd8);
    in_data = 8'hCC;
    @(negedge clk);
    check("t6_mid_valid", {31'd0, out_valid}, 32'd0);
    push(8'd6);
    check("t6_out_valid", {31'd0, out_valid}, 32'd1);
    check("t6_out_max", {24'd0, out_max}, 32'd8);
    check_idx("t6_out_idx", 8'd1);
    take("t6");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
